// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer letting two single-word requesters share one
// synchronous single-port RAM; read data is routed back to the requester that issued it.
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              own_q, own_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              pick1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      own_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      own_q       <= own_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    own_d       = own_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    // On a tie the requester that did not win last time takes the grant.
    pick1       = m1_req_i & (~m0_req_i | ~rr_last_q);
    case (state_q)
      IDLE: begin
        if (m0_req_i | m1_req_i) begin
          state_d   = ACCESS;
          own_d     = pick1;
          rr_last_d = pick1;
          we_d      = pick1 ? m1_we_i    : m0_we_i;
          addr_d    = pick1 ? m1_addr_i  : m0_addr_i;
          wdata_d   = pick1 ? m1_wdata_i : m0_wdata_i;
        end
      end
      ACCESS: begin
        cnt_d   = '0;
        state_d = we_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          if (own_q) begin
            m1_rvalid_d = 1'b1;
            m1_rdata_d  = ram_dout_i;
          end else begin
            m0_rvalid_d = 1'b1;
            m0_rdata_d  = ram_dout_i;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_we_o    = (state_q == ACCESS) & we_q;
  assign ram_addr_o  = addr_q;
  assign ram_din_o   = wdata_q;
  assign m0_gnt_o    = (state_q == ACCESS) & ~own_q;
  assign m1_gnt_o    = (state_q == ACCESS) & own_q;
  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM (RD_LAT=1),
// preloaded with 8'h10+address.
module tb_ram_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;

  int n_chk = 0;
  int n_fail = 0;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  // Single-port RAM, one-cycle read latency; contents preloaded during the first reset.
  logic [DATA_W-1:0] mem [16];
  logic              mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!rst_n && !mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
      mem_ready <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from requester m; for reads exp_rd is the required data.
  task automatic xfer(input bit m, input bit we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd);
    bit got;
    got = 1'b0;
    if (!m) begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = m ? m1_gnt : m0_gnt;
    end
    check("gnt_seen", 32'(got), 32'd1);
    if (!m) m0_req = 1'b0; else m1_req = 1'b0;
    if (!got) return;
    check("gnt_other", 32'(m ? m0_gnt : m1_gnt), 32'd0);
    check("ram_we", 32'(ram_we), 32'(we));
    check("ram_addr", 32'(ram_addr), 32'(a));
    if (we) check("ram_din", 32'(ram_din), 32'(wd));
    if (we) begin
      tick();
      check("gnt_pulse", 32'(m ? m1_gnt : m0_gnt), 32'd0);
      check("ram_we_off", 32'(ram_we), 32'd0);
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        tick();
        check("rvalid_early", 32'(m0_rvalid | m1_rvalid), 32'd0);
        check("gnt_pulse", 32'(m ? m1_gnt : m0_gnt), 32'd0);
      end
      tick();
      check("rvalid_own", 32'(m ? m1_rvalid : m0_rvalid), 32'd1);
      check("rvalid_other", 32'(m ? m0_rvalid : m1_rvalid), 32'd0);
      check("rdata", 32'(m ? m1_rdata : m0_rdata), 32'(exp_rd));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int g, rv, cyc, last_cyc;

    // Reset with both requests asserted
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_din", 32'(ram_din), 32'd0);
      check("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      check("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    end
    m0_req = 1'b0; m1_req = 1'b0; rst_n = 1'b1;
    tick();
    check("idle_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);

    // Basic write then read-back on m0
    xfer(1'b0, 1'b1, 4'h1, 8'hAA, 8'h00);
    xfer(1'b0, 1'b0, 4'h1, 8'h00, 8'hAA);

    // Same-cycle write conflict right after reset: m0 wins the first tie
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 4'h2; m0_wdata = 8'h55;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 4'h3; m1_wdata = 8'h33;
    tick();
    check("cf_m0_gnt", 32'(m0_gnt), 32'd1);
    check("cf_m1_gnt", 32'(m1_gnt), 32'd0);
    check("cf_addr0", 32'(ram_addr), 32'h2);
    check("cf_din0", 32'(ram_din), 32'h55);
    m0_req = 1'b0;
    tick();
    check("cf_idle_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    tick();
    check("cf_m1_gnt2", 32'(m1_gnt), 32'd1);
    check("cf_we1", 32'(ram_we), 32'd1);
    check("cf_addr1", 32'(ram_addr), 32'h3);
    check("cf_din1", 32'(ram_din), 32'h33);
    m1_req = 1'b0;
    tick();
    xfer(1'b0, 1'b0, 4'h2, 8'h00, 8'h55);
    xfer(1'b1, 1'b0, 4'h3, 8'h00, 8'h33);

    // Both hold read requests: grants alternate m0,m1,... every 3 cycles
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'h2;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'h3;
    g = 0; rv = 0; last_cyc = 0;
    for (cyc = 0; cyc < 100 && rv < 8; cyc++) begin
      tick();
      if (m0_gnt | m1_gnt) begin
        check("rr_owner", 32'(m1_gnt), 32'(g % 2));
        if (g > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'(2 + RD_LAT));
        last_cyc = cyc;
        g++;
        if (g == 8) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
      if (m0_rvalid | m1_rvalid) begin
        check("rr_rv_both", 32'(m0_rvalid & m1_rvalid), 32'd0);
        check("rr_rv_owner", 32'(m1_rvalid), 32'(rv % 2));
        check("rr_rdata", 32'(m1_rvalid ? m1_rdata : m0_rdata), (rv % 2) ? 32'h33 : 32'h55);
        rv++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("rr_grants", 32'(g), 32'd8);
    check("rr_rvalids", 32'(rv), 32'd8);

    // Top address and untouched address 0 via m1
    xfer(1'b1, 1'b1, 4'hF, 8'hFF, 8'h00);
    xfer(1'b1, 1'b0, 4'hF, 8'h00, 8'hFF);
    xfer(1'b1, 1'b0, 4'h0, 8'h00, 8'h10);
    check("m0_rdata_held", 32'(m0_rdata), 32'h55);

    // Reset during WAIT of an m0 read drops the read
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'h1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = m0_gnt;
    end
    check("wr_gnt_seen", 32'(got), 32'd1);
    m0_req = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("wr_rvalid_rst", 32'(m0_rvalid), 32'd0);
    check("wr_rdata_rst", 32'(m0_rdata), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("wr_rvalid_after", 32'(m0_rvalid), 32'd0);
    end
    xfer(1'b1, 1'b0, 4'h2, 8'h00, 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
